// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues one-cycle read strobes to instruction memory,
// latches the returned word into IR and advances or redirects the program counter.
module instr_fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] IR,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              fetch_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALTED} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_r, cap_addr, pend_target;
    logic              pend_valid;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] ir_r;
    logic              ir_valid_r, err_r;
    logic              in_flight, done, timed_out;

    assign in_flight = (state == REQ) || (state == WAIT);
    assign done      = in_flight && imem_valid;
    assign timed_out = (state == WAIT) && !imem_valid &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (halt) state_nxt = HALTED;
                     else if (fetch) state_nxt = REQ;
            REQ:     state_nxt = imem_valid ? IDLE : WAIT;
            WAIT:    if (imem_valid || timed_out) state_nxt = IDLE;
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_rd   = (state == REQ);
        imem_addr = imem_rd ? cap_addr : '0;
        busy      = in_flight;
        halted    = (state == HALTED);
    end

    // A jump arriving in the completion cycle itself wins over an older pending one.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= '0;
            cap_addr    <= '0;
            pend_target <= '0;
            pend_valid  <= 1'b0;
            ir_r        <= '0;
            ir_valid_r  <= 1'b0;
            err_r       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!halt) begin
                        if (jump_en) pc_r <= jump_target;
                        if (fetch) begin
                            cap_addr   <= jump_en ? jump_target : pc_r;
                            ir_valid_r <= 1'b0;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (fetch) err_r <= 1'b1;
                    if (done) begin
                        ir_r       <= imem_data;
                        ir_valid_r <= 1'b1;
                        pc_r       <= jump_en    ? jump_target :
                                      pend_valid ? pend_target :
                                                   cap_addr + ADDR_W'(1);
                        pend_valid <= 1'b0;
                    end else if (timed_out) begin
                        err_r      <= 1'b1;
                        pend_valid <= 1'b0;
                    end else if (jump_en) begin
                        pend_valid  <= 1'b1;
                        pend_target <= jump_target;
                    end
                end
                HALTED: if (fetch) err_r <= 1'b1;
                default: ;
            endcase

            if (state == WAIT && !imem_valid) wait_cnt <= wait_cnt + CNT_W'(1);
            else                              wait_cnt <= '0;
        end
    end

    assign pc        = pc_r;
    assign IR        = ir_r;
    assign ir_valid  = ir_valid_r;
    assign fetch_err = err_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit: a transaction-level model
// predicts each read address and the architectural state after every fetch.
module tb_instr_fetch_unit;

    localparam int TMO = 12;

    logic        clk = 1'b0;
    logic        reset, fetch, jump_en, halt, imem_valid;
    logic [15:0] jump_target, imem_data;
    logic        imem_rd, ir_valid, busy, halted, fetch_err;
    logic [15:0] imem_addr, IR, pc;

    instr_fetch_unit #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .fetch(fetch), .jump_en(jump_en),
        .jump_target(jump_target), .halt(halt), .imem_rd(imem_rd),
        .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
        .IR(IR), .ir_valid(ir_valid), .pc(pc), .busy(busy), .halted(halted),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        logic        irv;
        logic        err;
        int          len;
    } res_t;

    logic [15:0] addr_q[$];
    res_t        res_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [15:0] m_pc, m_ir;
    logic        m_irv, m_err;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Monitor: compares read addresses and post-transaction state as they appear
    int   blen = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (imem_rd === 1'b1) begin
            if (addr_q.size() == 0) check("unexpected_imem_rd", 32'd1, 32'd0);
            else check("imem_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
        end else begin
            check("imem_addr_idle_zero", 32'(imem_addr), 32'd0);
        end
        if (busy === 1'b1) begin
            blen++;
        end else if (prev_busy === 1'b1) begin
            if (res_q.size() == 0) begin
                check("unexpected_completion", 32'd1, 32'd0);
            end else begin
                res_t r;
                r = res_q.pop_front();
                check("IR", 32'(IR), 32'(r.ir));
                check("pc", 32'(pc), 32'(r.pc));
                check("ir_valid", 32'(ir_valid), 32'(r.irv));
                check("fetch_err", 32'(fetch_err), 32'(r.err));
                if (r.len >= 0) check("busy_cycles", 32'(blen), 32'(r.len));
            end
            blen = 0;
        end
        prev_busy = busy;
    end

    task automatic idle_inputs();
        fetch = 0; jump_en = 0; halt = 0; imem_valid = 0;
        jump_target = 16'(($urandom));
        imem_data   = 16'(($urandom));
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0;
        m_pc = 0; m_ir = 0; m_irv = 0; m_err = 0;
    endtask

    task automatic set_pc(input logic [15:0] t);
        jump_en = 1; jump_target = t; tick(); idle_inputs();
        m_pc = t;
    endtask

    // k = cycles after the strobe until data returns; k < 0 means never (timeout)
    task automatic do_fetch(input bit use_jmp, input logic [15:0] jt, input int k,
                            input bit busy_jmp, input logic [15:0] bjt,
                            input bit busy_fetch, input int bc, input logic [15:0] d);
        logic [15:0] addr;
        int last;
        res_t r;
        last = (k < 0) ? TMO + 1 : k + 1;
        addr = use_jmp ? jt : m_pc;
        if (use_jmp) m_pc = jt;
        m_irv = 0;
        if (busy_fetch) m_err = 1;
        if (k < 0) begin
            m_err = 1;
        end else begin
            m_ir  = d;
            m_irv = 1;
            m_pc  = busy_jmp ? bjt : addr + 16'd1;
        end
        addr_q.push_back(addr);
        r.ir = m_ir; r.pc = m_pc; r.irv = m_irv; r.err = m_err; r.len = last;
        res_q.push_back(r);

        fetch = 1; jump_en = use_jmp; jump_target = jt;
        tick();
        for (int c = 1; c <= last; c++) begin
            imem_valid  = (c == k + 1);
            imem_data   = (c == k + 1) ? d : 16'(($urandom));
            jump_en     = busy_jmp && (c == bc);
            jump_target = bjt;
            fetch       = busy_fetch && (c == bc);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1; idle_inputs();
        tick(); tick();
        do_reset();
        check("rst_IR", 32'(IR), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_ir_valid", 32'(ir_valid), 0);
        check("rst_fetch_err", 32'(fetch_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);

        // Basic fetch with two-cycle memory latency
        do_fetch(0, 0, 2, 0, 0, 0, 1, 16'hA5C3);
        tick();
        // Wrap of pc from all-ones with zero-wait memory
        set_pc(16'hFFFF);
        do_fetch(0, 0, 0, 0, 0, 0, 1, 16'h1234);
        tick();
        // Fetch and jump in the same idle cycle
        do_fetch(1, 16'h0040, 1, 0, 0, 0, 1, 16'h5A5A);
        tick();
        // Timeout
        do_fetch(0, 0, -1, 0, 0, 0, 1, 16'h0);
        tick();
        // Jump and second fetch during WAIT
        do_fetch(0, 0, 3, 1, 16'h0100, 1, 2, 16'hC0DE);
        tick();

        do_reset();
        for (int i = 0; i < 80; i++) begin
            int k, bc;
            bit bj, bf, uj;
            k  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            bc = int'($urandom_range(1, (k < 0) ? TMO + 1 : k + 1));
            uj = ($urandom_range(0, 3) == 0);
            bj = ($urandom_range(0, 3) == 0);
            bf = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) set_pc(16'(($urandom)));
            if ($urandom_range(0, 4) == 0) begin
                imem_valid = 1; tick(); idle_inputs();  // stray response, ignored
            end
            do_fetch(uj, 16'(($urandom)), k, bj, 16'(($urandom)), bf, bc, 16'(($urandom)));
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick();

        // Reset while waiting; the late response must be ignored
        begin
            res_t r;
            r.ir = 0; r.pc = 0; r.irv = 0; r.err = 0; r.len = -1;
            addr_q.push_back(m_pc);
            res_q.push_back(r);
            fetch = 1; tick(); fetch = 0;
            tick();
            reset = 1; tick(); reset = 0;
            imem_valid = 1; imem_data = 16'hBEEF; tick(); idle_inputs();
            m_pc = 0; m_ir = 0; m_irv = 0; m_err = 0;
            tick();
            check("post_rst_IR", 32'(IR), 0);
            check("post_rst_ir_valid", 32'(ir_valid), 0);
        end

        // Halt is sticky; fetch while halted only flags an error
        halt = 1; fetch = 1; jump_en = 1; tick(); idle_inputs();
        fetch = 1; tick(); idle_inputs();
        tick(); tick();
        check("halted", 32'(halted), 1);
        check("halted_busy", 32'(busy), 0);
        check("halted_fetch_err", 32'(fetch_err), 1);
        check("halted_pc", 32'(pc), 0);
        do_reset();
        check("unhalt_halted", 32'(halted), 0);
        check("unhalt_pc", 32'(pc), 0);
        check("unhalt_fetch_err", 32'(fetch_err), 0);

        tick(); tick();
        check("addr_q_drained", 32'(addr_q.size()), 0);
        check("res_q_drained", 32'(res_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
